pc_fetch_ctrl: RTL

//   Fetch-stage program counter and redirect controller. Consumes br_sel/br_target from the
//   EX-stage branch unit and jump requests from ID, owns the PC register, and drives the

---
 rtl/pc_fetch_ctrl_if.sv | 38 +++
 rtl/pc_fetch_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage control bundle between the PC/redirect controller and the pipeline.
// Carries hazard/redirect requests in and fetch address/valid/flush out.
// Optional statistics counters appear when FETCH_STATS_EN is defined.
interface pc_fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              br_sel;
  logic [ADDR_W-1:0] br_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              if_valid;
  logic              flush;
`ifdef FETCH_STATS_EN
  logic [15:0]       redirect_cnt;
  logic [15:0]       stall_cnt;
`endif

  // Controller side: consumes requests, owns the PC.
  modport master (
    input  stall, br_sel, br_target, jump, jump_target,
`ifdef FETCH_STATS_EN
    output redirect_cnt, stall_cnt,
`endif
    output pc, pc_plus4, if_valid, flush
  );

  // Pipeline side: raises requests, consumes the fetch address.
  modport slave (
    output stall, br_sel, br_target, jump, jump_target,
`ifdef FETCH_STATS_EN
    input  redirect_cnt, stall_cnt,
`endif
    input  pc, pc_plus4, if_valid, flush
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register and redirect controller (BOOT/RUN/SHADOW FSM).
// Latency: redirect target loaded at the edge where flush is high; stall holds PC.
// Optional FETCH_STATS_EN adds saturating redirect/stall counters.
module pc_fetch_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0040_0000,
  parameter int                SHADOW_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_ctrl_if.master  fetch
);

  typedef enum logic [1:0] {BOOT, RUN, SHADOW} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
  localparam logic [3:0]        SHADOW_INIT = 4'(SHADOW_CYC);

  state_t            state, state_nxt;
  logic [3:0]        shadow_cnt, shadow_cnt_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              if_valid_q;
  logic              take_br, take_jump, redirect;

  // Redirect acceptance: only in RUN, branch wins over jump.
  always_comb begin
    take_br   = (state == RUN) && fetch.br_sel;
    take_jump = (state == RUN) && fetch.jump && !fetch.br_sel;
    redirect  = take_br || take_jump;
  end

  // Next-state, shadow countdown and next-PC selection.
  always_comb begin
    state_nxt      = state;
    shadow_cnt_nxt = shadow_cnt;
    pc_nxt         = pc_q;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (take_br) begin
          pc_nxt         = fetch.br_target & ~ALIGN_MASK;
          state_nxt      = SHADOW;
          shadow_cnt_nxt = SHADOW_INIT;
        end else if (take_jump) begin
          pc_nxt         = fetch.jump_target & ~ALIGN_MASK;
          state_nxt      = SHADOW;
          shadow_cnt_nxt = SHADOW_INIT;
        end else if (!fetch.stall) begin
          pc_nxt = pc_q + PC_STEP;
        end
      end
      SHADOW: begin
        // Countdown runs through stalls so the window tracks wall-clock cycles.
        shadow_cnt_nxt = shadow_cnt - 4'd1;
        if (shadow_cnt <= 4'd1) begin
          state_nxt = RUN;
        end
        if (!fetch.stall) begin
          pc_nxt = pc_q + PC_STEP;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // State, PC and fetch-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      shadow_cnt <= 4'd0;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      shadow_cnt <= shadow_cnt_nxt;
      pc_q       <= pc_nxt;
      // BOOT lasts exactly one cycle, so every edge after reset leaves a valid fetch.
      if_valid_q <= 1'b1;
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.pc_plus4 = pc_q + PC_STEP;
  assign fetch.if_valid = if_valid_q;
  assign fetch.flush    = redirect;

`ifdef FETCH_STATS_EN
  logic [15:0] redirect_cnt_q, stall_cnt_q;

  // Saturating event counters; BOOT cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else if (state != BOOT) begin
      if (redirect && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
      if (fetch.stall && !redirect && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign fetch.redirect_cnt = redirect_cnt_q;
  assign fetch.stall_cnt    = stall_cnt_q;
`endif

endmodule
